// File: rtl/par_pkg.sv
// Shared types and constants for the parity-protected word path (transmit and receive sides).
package par_pkg;

  localparam int PAR_DATA_BITS  = 4;
  localparam int PAR_FRAME_BITS = 7;

  typedef struct packed {
    logic x1;
    logic x2;
    logic x3;
    logic x4;
    logic parity;
    logic all_ones;
  } Parity_struct;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } par_rx_state_e;

endpackage

// File: rtl/par_calc.sv
// Even-parity and all-ones calculator for a 4-bit word; shared by both ends of the link
// so the transmitter and the receiver always agree on the parity function.
module par_calc (
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  output logic parity,
  output logic all_ones
);

  assign parity   = x1 ^ x2 ^ x3 ^ x4;
  assign all_ones = x1 & x2 & x3 & x4;

endmodule

// File: rtl/par_rx.sv
// Framed serial receiver (start, x1..x4, parity, stop) with parity/framing checks and a
// valid/ready output. Optional saturating error counter enabled by PAR_RX_ERRCNT_EN.
module par_rx
  import par_pkg::*;
#(
  parameter int ERRCNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bit_en,
  input  logic         sin,
  output logic         out_valid,
  input  logic         out_ready,
  output Parity_struct out_word,
  output logic         parity_err,
  output logic         frame_err,
  output logic         overrun
`ifdef PAR_RX_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_count
`endif
);

  par_rx_state_e r_state;
  par_rx_state_e w_next;

  logic [1:0]   r_bit_idx;
  logic [3:0]   r_x;
  logic         r_par;

  logic         w_start;
  logic         w_shift_en;
  logic         w_par_en;
  logic         w_done;
  logic         w_last_data;

  logic         w_exp_par;
  logic         w_all_ones;
  logic         w_pe;
  logic         w_fe;
  logic         w_load;

  Parity_struct r_word;
  logic         r_valid;
  logic         r_pe;
  logic         r_fe;
  logic         r_overrun;

  assign w_last_data = (r_bit_idx == 2'(PAR_DATA_BITS - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // FSM: next state, advancing only on bit strobes
  always_comb begin
    w_next = r_state;
    if (bit_en) begin
      case (r_state)
        IDLE:    if (!sin) w_next = DATA;
        DATA:    if (w_last_data) w_next = PAR;
        PAR:     w_next = STOP;
        STOP:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // FSM: per-state strobes
  always_comb begin
    w_start    = 1'b0;
    w_shift_en = 1'b0;
    w_par_en   = 1'b0;
    w_done     = 1'b0;
    if (bit_en) begin
      case (r_state)
        IDLE:    w_start    = ~sin;
        DATA:    w_shift_en = 1'b1;
        PAR:     w_par_en   = 1'b1;
        STOP:    w_done     = 1'b1;
        default: ;
      endcase
    end
  end

  // Deserialiser: r_x[0] holds x1, the first data bit on the wire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_idx <= '0;
      r_x       <= '0;
      r_par     <= 1'b0;
    end else begin
      if (w_start)         r_bit_idx <= '0;
      else if (w_shift_en) r_bit_idx <= r_bit_idx + 2'd1;
      if (w_shift_en)      r_x[r_bit_idx] <= sin;
      if (w_par_en)        r_par <= sin;
    end
  end

  par_calc u_calc (
    .x1       (r_x[0]),
    .x2       (r_x[1]),
    .x3       (r_x[2]),
    .x4       (r_x[3]),
    .parity   (w_exp_par),
    .all_ones (w_all_ones)
  );

  // The stop bit is being sampled on the completing strobe, so sin is the stop bit here
  assign w_pe   = r_par ^ w_exp_par;
  assign w_fe   = ~sin;
  assign w_load = w_done & (~r_valid | out_ready);

  // Output register: loads when empty or draining this cycle, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_pe      <= 1'b0;
      r_fe      <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_word.x1       <= r_x[0];
        r_word.x2       <= r_x[1];
        r_word.x3       <= r_x[2];
        r_word.x4       <= r_x[3];
        r_word.parity   <= r_par;
        r_word.all_ones <= w_all_ones;
        r_pe            <= w_pe;
        r_fe            <= w_fe;
        r_valid         <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_done && !w_load) r_overrun <= 1'b1;
    end
  end

  assign out_valid  = r_valid;
  assign out_word   = r_word;
  assign parity_err = r_pe;
  assign frame_err  = r_fe;
  assign overrun    = r_overrun;

`ifdef PAR_RX_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_err_cnt;

  // Counts every completed bad frame, dropped ones included, and sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_done && (w_pe || w_fe) && (r_err_cnt != {ERRCNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_par_rx.sv
// Directed bench for par_rx: clean, parity-error, framing-error, backpressure, coincident
// transfer, mid-frame reset and (with PAR_RX_ERRCNT_EN) counter saturation at ERRCNT_W=2.
module tb_par_rx;
  import par_pkg::*;

  localparam int ERRCNT_W = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bit_en = 1'b0;
  logic         sin = 1'b1;
  logic         out_ready = 1'b0;
  logic         out_valid;
  Parity_struct out_word;
  logic         parity_err;
  logic         frame_err;
  logic         overrun;
`ifdef PAR_RX_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  par_rx #(.ERRCNT_W(ERRCNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .sin        (sin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
`ifdef PAR_RX_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    bit_en = 1'b1;
    sin    = b;
    @(posedge clk); #1;
    bit_en = 1'b0;
    sin    = 1'b1;
    for (int g = 0; g < gap; g++) begin
      sin = 1'b0;
      @(posedge clk); #1;
    end
    sin = 1'b1;
  endtask

  // Sends the first n bits of a frame, first bit on the wire in f[6]
  task automatic send_bits(input logic [6:0] f, input int n, input int gap);
    for (int i = 6; i > 6 - n; i--) send_bit(f[i], gap);
  endtask

  task automatic xfer(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk(tag, 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_word(input string tag, input logic [5:0] w, input logic pe, input logic fe);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_word"},  32'(out_word),  32'(w));
    chk({tag, "_pe"},    32'(parity_err), 32'(pe));
    chk({tag, "_fe"},    32'(frame_err),  32'(fe));
  endtask

  initial begin
    #12;
    chk("rst_valid",   32'(out_valid),  32'd0);
    chk("rst_word",    32'(out_word),   32'd0);
    chk("rst_pe",      32'(parity_err), 32'd0);
    chk("rst_fe",      32'(frame_err),  32'd0);
    chk("rst_overrun", 32'(overrun),    32'd0);
`ifdef PAR_RX_ERRCNT_EN
    chk("rst_errcnt",  32'(err_count),  32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean frame, data 1011 parity 1
    send_bits(7'b0101111, 7, 0);
    chk_word("clean", 6'b101110, 1'b0, 1'b0);
    xfer("clean_xfer");

    // Parity error, data 1111 parity 1
    send_bits(7'b0111111, 7, 0);
    chk_word("perr", 6'b111111, 1'b1, 1'b0);
`ifdef PAR_RX_ERRCNT_EN
    chk("perr_cnt", 32'(err_count), 32'd1);
`endif
    xfer("perr_xfer");

    // Framing error then a clean frame 0110 parity 0
    send_bits(7'b0101110, 7, 0);
    chk_word("ferr", 6'b101110, 1'b0, 1'b1);
`ifdef PAR_RX_ERRCNT_EN
    chk("ferr_cnt", 32'(err_count), 32'd2);
`endif
    xfer("ferr_xfer");
    send_bits(7'b0011001, 7, 0);
    chk_word("after_ferr", 6'b011000, 1'b0, 1'b0);
    xfer("after_ferr_xfer");

    // Backpressure: two back-to-back frames with out_ready low
    send_bits(7'b0110001, 7, 0);
    chk_word("bp_first", 6'b110000, 1'b0, 1'b0);
    chk("bp_no_ovr", 32'(overrun), 32'd0);
    send_bits(7'b0000111, 7, 0);
    chk_word("bp_held", 6'b110000, 1'b0, 1'b0);
    chk("bp_overrun", 32'(overrun), 32'd1);
`ifdef PAR_RX_ERRCNT_EN
    chk("bp_cnt", 32'(err_count), 32'd2);
`endif
    xfer("bp_xfer");

    // Completion coincides with transfer
    do_reset();
    chk("co_rst_ovr", 32'(overrun), 32'd0);
`ifdef PAR_RX_ERRCNT_EN
    chk("co_rst_cnt", 32'(err_count), 32'd0);
`endif
    send_bits(7'b0100011, 7, 0);
    chk_word("co_first", 6'b100010, 1'b0, 1'b0);
    send_bits(7'b0010011, 6, 0);
    out_ready = 1'b1;
    send_bit(1'b1, 0);
    out_ready = 1'b0;
    chk_word("co_second", 6'b010010, 1'b0, 1'b0);
    chk("co_overrun", 32'(overrun), 32'd0);
    xfer("co_xfer");

    // Reset after the 3rd data bit, then a clean frame with gapped strobes
    send_bits(7'b0111111, 4, 0);
    rst_n = 1'b0;
    #2;
    chk("mid_valid",   32'(out_valid),  32'd0);
    chk("mid_word",    32'(out_word),   32'd0);
    chk("mid_pe",      32'(parity_err), 32'd0);
    chk("mid_overrun", 32'(overrun),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_no_pulse", 32'(out_valid), 32'd0);
    send_bits(7'b0101111, 7, 2);
    chk_word("mid_after", 6'b101110, 1'b0, 1'b0);
    xfer("mid_xfer");

`ifdef PAR_RX_ERRCNT_EN
    // Saturation at 3 with a 2-bit counter
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_bits(7'b0111111, 7, 0);
      out_ready = 1'b1;
      chk("sat_cnt", 32'(err_count), (k < 3) ? (k + 1) : 3);
    end
    out_ready = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/par_rx.md
# par_rx

Serial receiver and checker for 4-bit parity-protected words, the receive end of the parity generator path. It deserialises a framed bit stream (start, x1..x4, parity, stop) into a `Parity_struct`, recomputes parity and all_ones, and flags parity and framing errors. It presents each word through a valid/ready output handshake to downstream logic, and optionally keeps a saturating error count.

## Interface
Parameters:
- ERRCNT_W, 8: width of the error counter; only used when PAR_RX_ERRCNT_EN is defined.

Ports:
- clk  in  1  system clock; one clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- bit_en  in  1  bit strobe; `sin` is sampled only on cycles where bit_en=1.
- sin  in  1  serial input; idle level is 1.
- out_valid  out  1  a received word is held on the outputs.
- out_ready  in  1  downstream accepts the word.
- out_word  out  Parity_struct  x1..x4 as received, parity as received, all_ones recomputed.
- parity_err  out  1  received parity ≠ x1^x2^x3^x4; qualified by out_valid.
- frame_err  out  1  stop bit sampled as 0; qualified by out_valid.
- overrun  out  1  sticky; a completed frame was dropped because out_valid was still held. Cleared only by reset.
- err_count  out  ERRCNT_W  saturating count of frames with a parity or framing error; present only with PAR_RX_ERRCNT_EN.

## Operation
- FSM states: IDLE, DATA, PAR, STOP. All transitions happen only on bit_en cycles.
- IDLE: when sin=0, go to DATA with bit index 0. When sin=1, stay in IDLE.
- DATA: shift sin into x1, x2, x3, x4 in that order (x1 first). After the 4th bit, go to PAR.
- PAR: capture the received parity bit, then go to STOP.
- STOP: capture the stop bit, then go to IDLE. The frame is complete at this point.
- Even parity: parity_err = rx_parity ^ x1 ^ x2 ^ x3 ^ x4.
- all_ones = x1 & x2 & x3 & x4, computed from the received data.
- On frame completion:
  - If out_valid=0, or out_valid=1 with out_ready=1 in the same cycle, load the output register and set out_valid=1.
  - Otherwise, discard the frame and set overrun=1.
- Handshake:
  - A word transfers on a cycle where out_valid=1 and out_ready=1.
  - out_valid clears on the cycle after the transfer, unless a new frame completes in that same cycle.
  - out_word, parity_err and frame_err stay stable while out_valid=1 and out_ready=0.
- No start-bit glitch rejection. A stop bit of 0 still returns the FSM to IDLE; the next start is searched from the following bit_en.

## Timing
- Reset values: state=IDLE, out_valid=0, out_word=0, parity_err=0, frame_err=0, overrun=0, err_count=0.
- Latency: out_valid rises on the clock edge following the bit_en cycle that samples the stop bit.
- A frame occupies 7 bit_en strobes.
- Back-to-back frames are allowed: a start bit may arrive on the bit_en immediately after the stop bit.
- If bit_en is held at 1 continuously, the block receives one bit per clock.
- Simultaneous transfer and completion: the new word loads, out_valid stays 1, and no overrun is raised.
- Reset asserted mid-frame: the partial frame is discarded immediately and asynchronously, with no output pulse and no counter change.

## Configuration
- PAR_RX_ERRCNT_EN defined:
  - err_count exists.
  - It increments by 1 on every completed frame where parity_err or frame_err is set, including dropped (overrun) frames.
  - It saturates at 2^ERRCNT_W−1.
- PAR_RX_ERRCNT_EN undefined: the err_count port and counter logic are absent; all other behaviour is identical.

## Structure
- Package par_pkg holds:
  - typedef Parity_struct: packed struct with x1, x2, x3, x4, parity, all_ones. It is shared with the transmit side.
  - State enum par_rx_state_e.
  - Constants PAR_DATA_BITS=4 and PAR_FRAME_BITS=7.
- Sub-module par_calc: combinational; takes x1..x4 and produces the expected parity and all_ones. The transmit side reuses it, so both ends compute parity identically.

## Test plan
- Clean frame, bit_en=1 constantly: sin 0,1,0,1,1,1,1 (data 1011, parity 1, stop 1) → out_valid=1, out_word x1..x4=1,0,1,1, parity=1, all_ones=0, both error flags 0.
- Parity error: data 1111, parity bit 1 → parity_err=1, all_ones=1; err_count goes 0→1 when PAR_RX_ERRCNT_EN is defined.
- Framing error: valid data, stop bit 0 → frame_err=1, FSM in IDLE, and a following clean frame is received correctly.
- Backpressure: out_ready=0 while 2 frames complete → first word held stable, overrun=1, second frame dropped. Then out_ready=1 → first word transfers and out_valid falls.
- Completion coincides with a transfer → new word loads, out_valid stays 1, overrun stays 0.
- rst_n pulsed low after the 3rd data bit → all outputs at reset values, no out_valid. Subsequent frame decodes correctly.
- With ERRCNT_W=2, send 5 bad frames → err_count saturates at 3.
